// File: rtl/irq_pending_arbiter.sv
// Sticky-pending interrupt arbiter: rising edges on req latch pending bits, and the
// highest enabled pending index is presented until it is acknowledged or times out.
module irq_pending_arbiter #(
   parameter int unsigned WAIT_MAX = 15
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] req,
   input  logic [3:0] mask,
   input  logic       irq_ack,
   output logic       irq_valid,
   output logic [1:0] irq_id,
   output logic [3:0] pending,
   output logic       timeout
);

   typedef enum logic {
      IDLE    = 1'b0,
      PRESENT = 1'b1
   } state_t;

   localparam logic       TIMEOUT_EN = (WAIT_MAX != 0);
   localparam logic [7:0] LAST_CYCLE = (WAIT_MAX != 0) ? 8'(WAIT_MAX - 1) : 8'd0;

   state_t     state_q, state_d;
   logic [3:0] req_dly_q, req_dly_d;
   logic [3:0] pending_q, pending_d;
   logic [1:0] irq_id_q, irq_id_d;
   logic [7:0] timer_q, timer_d;
   logic       timeout_q, timeout_d;
   logic [3:0] rise;
   logic [3:0] eligible;
   logic [1:0] sel_id;

   always_comb begin
      req_dly_d = req;
      rise      = req & ~req_dly_q;
      eligible  = pending_q & mask;

      // Ascending scan so the highest set index wins.
      sel_id = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         if (eligible[i]) begin
            sel_id = 2'(i);
         end
      end

      state_d   = state_q;
      irq_id_d  = irq_id_q;
      timer_d   = timer_q;
      timeout_d = 1'b0;
      pending_d = pending_q;

      case (state_q)
         IDLE: begin
            timer_d = '0;
            if (|eligible) begin
               state_d  = PRESENT;
               irq_id_d = sel_id;
            end
         end
         PRESENT: begin
            if (irq_ack) begin
               pending_d[irq_id_q] = 1'b0;
               state_d             = IDLE;
            end else if (TIMEOUT_EN && (timer_q == LAST_CYCLE)) begin
               state_d   = IDLE;
               timeout_d = 1'b1;
            end else begin
               timer_d = timer_q + 8'd1;
            end
         end
      endcase

      // Applied after the ack clear so a same-cycle new edge keeps the bit set.
      pending_d = pending_d | rise;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         req_dly_q <= '0;
         pending_q <= '0;
         irq_id_q  <= '0;
         timer_q   <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         req_dly_q <= req_dly_d;
         pending_q <= pending_d;
         irq_id_q  <= irq_id_d;
         timer_q   <= timer_d;
         timeout_q <= timeout_d;
      end
   end

   assign irq_valid = (state_q == PRESENT);
   assign irq_id    = irq_id_q;
   assign pending   = pending_q;
   assign timeout   = timeout_q;

endmodule

// File: tb/tb_irq_pending_arbiter.sv
// Directed bench for irq_pending_arbiter (WAIT_MAX=4): each step queues the expected
// post-edge {irq_valid, irq_id, pending, timeout} and compares it after the edge.
module tb_irq_pending_arbiter;

   logic       clk;
   logic       rst_n;
   logic [3:0] req;
   logic [3:0] mask;
   logic       irq_ack;
   logic       irq_valid;
   logic [1:0] irq_id;
   logic [3:0] pending;
   logic       timeout;

   typedef struct {
      string      tag;
      logic [7:0] exp;
   } exp_t;

   exp_t sb[$];
   int   n_cmp  = 0;
   int   n_fail = 0;

   irq_pending_arbiter #(
      .WAIT_MAX(4)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (req),
      .mask     (mask),
      .irq_ack  (irq_ack),
      .irq_valid(irq_valid),
      .irq_id   (irq_id),
      .pending  (pending),
      .timeout  (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] pk(input logic v, input logic [1:0] id,
                                     input logic [3:0] p, input logic t);
      return {v, id, p, t};
   endfunction

   // Drive inputs, queue the expected outputs after the next edge, then check them.
   task automatic step(input logic rn, input logic [3:0] r, input logic [3:0] m,
                       input logic a, input logic [7:0] exp, input string tag);
      exp_t e;
      exp_t got;
      logic [7:0] obs;
      rst_n   = rn;
      req     = r;
      mask    = m;
      irq_ack = a;
      e.tag = tag;
      e.exp = exp;
      sb.push_back(e);
      @(posedge clk);
      #1;
      got = sb.pop_front();
      obs = {irq_valid, irq_id, pending, timeout};
      n_cmp++;
      assert (obs === got.exp) else begin
         n_fail++;
         $error("FAIL %s: observed v/id/pend/to=%b expected %b", got.tag, obs, got.exp);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; req = '0; mask = 4'hF; irq_ack = 1'b0;

      // Reset state
      step(0, 4'b0000, 4'b1111, 0, pk(0, 2'd0, 4'b0000, 0), "reset0");
      step(0, 4'b0000, 4'b1111, 0, pk(0, 2'd0, 4'b0000, 0), "reset1");
      step(1, 4'b0000, 4'b1111, 0, pk(0, 2'd0, 4'b0000, 0), "idle_after_reset");

      // Single request: latency and ack
      step(1, 4'b0100, 4'b1111, 0, pk(0, 2'd0, 4'b0100, 0), "r029_pend");
      step(1, 4'b0100, 4'b1111, 0, pk(1, 2'd2, 4'b0100, 0), "r029_present");
      step(1, 4'b0100, 4'b1111, 1, pk(0, 2'd2, 4'b0000, 0), "r029_ack");
      step(1, 4'b0000, 4'b1111, 0, pk(0, 2'd2, 4'b0000, 0), "r029_idle");

      // Two simultaneous requests: priority and minimum gap
      step(1, 4'b1010, 4'b1111, 0, pk(0, 2'd2, 4'b1010, 0), "r030_pend");
      step(1, 4'b1010, 4'b1111, 0, pk(1, 2'd3, 4'b1010, 0), "r030_id3");
      step(1, 4'b1010, 4'b1111, 1, pk(0, 2'd3, 4'b0010, 0), "r030_ack3_gap");
      step(1, 4'b1010, 4'b1111, 0, pk(1, 2'd1, 4'b0010, 0), "r030_id1");
      step(1, 4'b0000, 4'b1111, 1, pk(0, 2'd1, 4'b0000, 0), "r030_ack1");
      step(1, 4'b0000, 4'b1111, 0, pk(0, 2'd1, 4'b0000, 0), "r030_idle");

      // No preemption while presenting
      step(1, 4'b0001, 4'b1111, 0, pk(0, 2'd1, 4'b0001, 0), "r031_pend");
      step(1, 4'b0001, 4'b1111, 0, pk(1, 2'd0, 4'b0001, 0), "r031_id0");
      step(1, 4'b1001, 4'b1111, 0, pk(1, 2'd0, 4'b1001, 0), "r031_hold_id0");
      step(1, 4'b1001, 4'b1111, 1, pk(0, 2'd0, 4'b1000, 0), "r031_ack0");
      step(1, 4'b1001, 4'b1111, 0, pk(1, 2'd3, 4'b1000, 0), "r031_id3");
      step(1, 4'b0000, 4'b1111, 1, pk(0, 2'd3, 4'b0000, 0), "r031_ack3");

      // Masked line latches but is not selected; ack in IDLE ignored
      step(1, 4'b1000, 4'b0111, 0, pk(0, 2'd3, 4'b1000, 0), "r033_masked_pend");
      step(1, 4'b1000, 4'b0111, 1, pk(0, 2'd3, 4'b1000, 0), "r019_idle_ack");
      step(1, 4'b1000, 4'b1111, 0, pk(1, 2'd3, 4'b1000, 0), "r033_unmask");
      step(1, 4'b0000, 4'b1111, 1, pk(0, 2'd3, 4'b0000, 0), "r033_ack");

      // Same-cycle ack and new edge on the presented line: set wins
      step(1, 4'b0100, 4'b1111, 0, pk(0, 2'd3, 4'b0100, 0), "r018_pend");
      step(1, 4'b0000, 4'b1111, 0, pk(1, 2'd2, 4'b0100, 0), "r018_present");
      step(1, 4'b0100, 4'b1111, 1, pk(0, 2'd2, 4'b0100, 0), "r018_set_wins");
      step(1, 4'b0100, 4'b1111, 0, pk(1, 2'd2, 4'b0100, 0), "r018_represent");
      step(1, 4'b0100, 4'b1111, 1, pk(0, 2'd2, 4'b0000, 0), "r018_ack");
      step(1, 4'b0000, 4'b1111, 0, pk(0, 2'd2, 4'b0000, 0), "r018_idle");

      // Timeout after exactly 4 presented cycles, then re-presentation
      step(1, 4'b0001, 4'b1111, 0, pk(0, 2'd2, 4'b0001, 0), "r032_pend");
      for (int k = 0; k < 4; k++)
         step(1, 4'b0001, 4'b1111, 0, pk(1, 2'd0, 4'b0001, 0), $sformatf("r032_valid%0d", k));
      step(1, 4'b0001, 4'b1111, 0, pk(0, 2'd0, 4'b0001, 1), "r032_timeout");
      step(1, 4'b0001, 4'b1111, 0, pk(1, 2'd0, 4'b0001, 0), "r032_represent");

      // Ack on the final permitted cycle beats timeout
      for (int k = 1; k < 4; k++)
         step(1, 4'b0001, 4'b1111, 0, pk(1, 2'd0, 4'b0001, 0), $sformatf("r024_valid%0d", k));
      step(1, 4'b0001, 4'b1111, 1, pk(0, 2'd0, 4'b0000, 0), "r024_ack_last");
      step(1, 4'b0000, 4'b1111, 0, pk(0, 2'd0, 4'b0000, 0), "r024_no_timeout");

      // Reset during PRESENT; request held through release
      step(1, 4'b0010, 4'b1111, 0, pk(0, 2'd0, 4'b0010, 0), "r034_pend");
      step(1, 4'b0010, 4'b1111, 0, pk(1, 2'd1, 4'b0010, 0), "r034_present");
      step(0, 4'b0010, 4'b1111, 0, pk(0, 2'd0, 4'b0000, 0), "r034_reset_abort");
      step(0, 4'b0010, 4'b1111, 0, pk(0, 2'd0, 4'b0000, 0), "r034_reset_hold");
      step(1, 4'b0010, 4'b1111, 0, pk(0, 2'd0, 4'b0010, 0), "r034_edge_post_reset");
      step(1, 4'b0010, 4'b1111, 0, pk(1, 2'd1, 4'b0010, 0), "r034_present2");
      step(1, 4'b0010, 4'b1111, 1, pk(0, 2'd1, 4'b0000, 0), "r034_ack");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/irq_pending_arbiter.md
IRQ_PENDING_ARBITER -- requirements
Module: irq_pending_arbiter

Interface
REQ-001 Parameter WAIT_MAX, default 15: maximum cycles irq_valid stays high without irq_ack; range 0..255; 0 disables timeout.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset; synchronous, active-low.
REQ-004 req  input  4  raw request lines; index 3 highest priority, index 0 lowest.
REQ-005 mask  input  4  enable per line; 1 = eligible for arbitration.
REQ-006 irq_ack  input  1  consumer acknowledge of the presented irq_id.
REQ-007 irq_valid  output  1  high while an index is presented.
REQ-008 irq_id  output  2  encoded index of the presented request.
REQ-009 pending  output  4  registered sticky pending bits.
REQ-010 timeout  output  1  one-cycle pulse when a presentation expires unacknowledged.

Function
REQ-011 Edge capture: registered copy req_d; pending[i] SHALL set on any cycle where req[i]=1 and req_d[i]=0.
REQ-012 Pending bits SHALL stay set regardless of later req level until cleared by acknowledge (REQ-017).
REQ-013 Masked lines SHALL still latch pending but SHALL NOT be selected.
REQ-014 FSM states IDLE and PRESENT only; IDLE is the reset state.
REQ-015 IDLE: if (pending & mask) != 0, the FSM SHALL register irq_id = highest set index of (pending & mask), enter PRESENT, and drive irq_valid=1 from the next cycle.
REQ-016 PRESENT: irq_id SHALL be held stable; no preemption by higher-priority arrivals or mask changes.
REQ-017 PRESENT with irq_ack=1: pending[irq_id] SHALL clear, FSM returns to IDLE, irq_valid=0 on the next cycle.
REQ-018 Same-cycle ack and new rising edge on the same line: set SHALL win; pending bit remains 1.
REQ-019 irq_ack in IDLE SHALL be ignored.
REQ-020 Latency: req rising sampled at edge N -> pending set after edge N -> irq_valid=1 after edge N+1 (two cycles from FSM IDLE).
REQ-021 Minimum gap: after an ack, at least one IDLE cycle (irq_valid=0) SHALL occur before the next presentation.
REQ-022 Timer: 8-bit counter cleared on entry to PRESENT, increments each PRESENT cycle without ack.
REQ-023 If WAIT_MAX>0 and the counter equals WAIT_MAX-1 with irq_ack=0, timeout SHALL pulse high for one cycle, the FSM SHALL return to IDLE, and pending SHALL remain unchanged.
REQ-024 irq_ack on the final permitted cycle SHALL take precedence over timeout.
REQ-025 A timed-out but still pending and enabled line SHALL be re-presented via normal arbitration.

Reset
REQ-026 While rst_n=0 at a clock edge: FSM=IDLE, pending=0, req_d=0, timer=0, irq_valid=0, irq_id=0, timeout=0.
REQ-027 Reset mid-PRESENT SHALL abort the presentation and discard all pending requests.
REQ-028 A req line held high across reset release SHALL be captured as a new edge on the first post-reset cycle.

Verification
REQ-029 mask=1111, req 0000->0100 -> pending=0100 one cycle later, irq_valid=1 irq_id=2 the cycle after; ack -> pending=0000, irq_valid=0.
REQ-030 req 1010 same cycle, mask=1111 -> irq_id=3 first; after ack, one idle cycle, then irq_id=1.
REQ-031 Presenting id 0, req[3] rises -> irq_id stays 0 until ack, then irq_id=3 presented.
REQ-032 WAIT_MAX=4, no ack -> irq_valid high exactly 4 cycles, timeout pulse 1 cycle, pending unchanged, re-presented after one idle cycle.
REQ-033 mask=0111, req[3] rises -> pending=1000, irq_valid stays 0; mask->1111 -> irq_id=3 presented.
REQ-034 rst_n=0 during PRESENT -> next cycle all outputs 0; req held high through release -> pending set on first post-reset cycle.
